// File: rtl/axis_adc_acq_ctrl.sv
// Arm/trigger sequencer forwarding one decimated ADC burst; ADC_ACQ_LEVEL_TRIG_EN adds a level trigger.
// Latency: a sample accepted at cycle t is presented on m_axis at t+1.
// Backpressure: one-entry output register; a capture sample meeting a full, stalled register is dropped.
module axis_adc_acq_ctrl #(
  parameter int CNTR_WIDTH       = 16,
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [CNTR_WIDTH-1:0]       cfg_total,
  input  logic [CNTR_WIDTH-1:0]       cfg_dec,
  input  logic [15:0]                 cfg_level,
  input  logic                        cfg_chan,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        trg_ext,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic [1:0]                  sts_state,
  output logic [CNTR_WIDTH-1:0]       sts_count,
  output logic                        sts_overflow,
  output logic                        busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [CNTR_WIDTH-1:0] total_q, dec_q, dec_cnt;
  logic                  trg_d, trg_pend;
  logic                  accept, start_ok, trg_edge, lvl_fire, fire, cap, is_last, load;

  assign accept   = s_axis_tvalid && (dec_cnt == dec_q);
  assign start_ok = start && !abort && (cfg_total != '0) &&
                    ((state == S_IDLE) || (state == S_DONE));
  assign trg_edge = trg_ext && !trg_d;
  assign is_last  = (sts_count == total_q - CNTR_WIDTH'(1));

`ifdef ADC_ACQ_LEVEL_TRIG_EN
  logic signed [15:0] lvl_cur, prev_q;
  logic               prev_vld;

  assign lvl_cur  = cfg_chan ? s_axis_tdata[16 +: 16] : s_axis_tdata[0 +: 16];
  assign lvl_fire = prev_vld && (prev_q < $signed(cfg_level)) && (lvl_cur >= $signed(cfg_level));

  // Previous value only tracks accepted samples while armed; arming forgets it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      prev_q   <= '0;
      prev_vld <= 1'b0;
    end else if (start_ok) begin
      prev_vld <= 1'b0;
    end else if ((state == S_ARMED) && accept) begin
      prev_q   <= lvl_cur;
      prev_vld <= 1'b1;
    end
  end
`else
  logic unused_lvl;
  assign unused_lvl = ^{cfg_level, cfg_chan};
  assign lvl_fire   = 1'b0;
`endif

  // Trigger sample itself (level) or first sample after the edge cycle (external) is sample 0.
  assign fire = !abort && (state == S_ARMED) && accept && (trg_pend || lvl_fire);
  assign cap  = fire || (!abort && (state == S_CAPTURE) && accept);
  assign load = cap && (!m_axis_tvalid || m_axis_tready);

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start_ok) state_nxt = S_ARMED;
        S_ARMED:        if (fire) state_nxt = is_last ? S_DONE : S_CAPTURE;
        S_CAPTURE:      if (accept && is_last) state_nxt = S_DONE;
        default:        state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= S_IDLE;
      total_q      <= '0;
      dec_q        <= '0;
      dec_cnt      <= '0;
      sts_count    <= '0;
      sts_overflow <= 1'b0;
      trg_d        <= 1'b0;
      trg_pend     <= 1'b0;
    end else begin
      state <= state_nxt;
      trg_d <= trg_ext;
      if (start_ok) begin
        total_q <= cfg_total;
        dec_q   <= cfg_dec;
      end
      if (start_ok)           dec_cnt <= '0;
      else if (s_axis_tvalid) dec_cnt <= accept ? '0 : dec_cnt + CNTR_WIDTH'(1);
      // Dropped samples still count so the burst keeps its nominal length.
      if (start_ok)  sts_count <= '0;
      else if (cap)  sts_count <= sts_count + CNTR_WIDTH'(1);
      if (start_ok)           sts_overflow <= 1'b0;
      else if (cap && !load)  sts_overflow <= 1'b1;
      if (start_ok || abort)                   trg_pend <= 1'b0;
      else if ((state == S_ARMED) && trg_edge) trg_pend <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (abort) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (load) begin
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= is_last;
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end
  end

  assign sts_state = state;
  assign busy      = (state == S_ARMED) || (state == S_CAPTURE) || m_axis_tvalid;

endmodule

// File: tb/tb_axis_adc_acq_ctrl.sv
// Bench for axis_adc_acq_ctrl: logged random stimulus replayed through an event-level burst model.
module tb_axis_adc_acq_ctrl;
  localparam int CW   = 16;
  localparam int DW   = 32;
  localparam int LOGN = 16384;

  typedef struct {
    logic [31:0] dat;
    logic        last;
    int          cyc;
  } beat_t;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [CW-1:0] cfg_total, cfg_dec;
  logic [15:0]   cfg_level;
  logic          cfg_chan, start, abort, trg_ext;
  logic [DW-1:0] s_axis_tdata, m_axis_tdata;
  logic          s_axis_tvalid, m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [1:0]    sts_state;
  logic [CW-1:0] sts_count;
  logic          sts_overflow, busy;

  axis_adc_acq_ctrl #(.CNTR_WIDTH(CW), .AXIS_TDATA_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_total(cfg_total), .cfg_dec(cfg_dec),
    .cfg_level(cfg_level), .cfg_chan(cfg_chan), .start(start), .abort(abort),
    .trg_ext(trg_ext), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .sts_state(sts_state), .sts_count(sts_count),
    .sts_overflow(sts_overflow), .busy(busy)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc++;

  int checks = 0;
  int errors = 0;

  // Inputs as sampled at each rising edge, indexed by edge number.
  bit        lg_vld[LOGN], lg_rdy[LOGN], lg_trg[LOGN], lg_ab[LOGN];
  bit [31:0] lg_dat[LOGN];

  beat_t beats[$];
  beat_t mb;
  bit    mon_en = 1'b0;
  bit    hv = 1'b0;
  logic [31:0] hd;
  logic        hl;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic r,
                       input logic t, input logic st, input logic ab);
    @(posedge aclk);
    #1;
    s_axis_tvalid = v; s_axis_tdata = d; m_axis_tready = r;
    trg_ext = t; start = st; abort = ab;
    lg_vld[cyc+1] = v; lg_dat[cyc+1] = d; lg_rdy[cyc+1] = r;
    lg_trg[cyc+1] = t; lg_ab[cyc+1]  = ab;
  endtask

  // Beat collection plus AXIS hold-stability while stalled.
  always @(negedge aclk) begin
    if (!aresetn) begin
      hv = 1'b0;
    end else begin
      if (hv && !lg_ab[cyc]) begin
        chk("axis_hold_vld", m_axis_tvalid, 1'b1);
        chk("axis_hold_dat", m_axis_tdata, hd);
        chk("axis_hold_last", m_axis_tlast, hl);
      end
      hv = m_axis_tvalid && !m_axis_tready;
      hd = m_axis_tdata;
      hl = m_axis_tlast;
      if (mon_en && m_axis_tvalid && m_axis_tready) begin
        mb.dat = m_axis_tdata; mb.last = m_axis_tlast; mb.cyc = cyc + 1;
        beats.push_back(mb);
      end
    end
  end

  function automatic int drain_at(input int ld, input int lim);
    for (int n = ld + 1; n <= lim; n++) if (lg_rdy[n]) return n;
    return lim + 1000;
  endfunction

  // rdy_mode: 0 held low, 1 held high, 2 random; window then a ready tail drains everything.
  task automatic run_burst(input int T, input int D, input int rdy_mode, input bit rnd_vld, input bit ramp);
    int s, e, k, lim, td, tw, pend;
    int acc[$];
    int cap[$];
    beat_t ex[$];
    beat_t b;
    bit ovf;
    logic v, r, t;
    logic [31:0] d, rampv, h_dat;
    logic h_vld, h_last;
    cfg_total = CW'(T);
    cfg_dec   = CW'(D);
`ifdef ADC_ACQ_LEVEL_TRIG_EN
    cfg_level = 16'h8000;
    cfg_chan  = 1'($urandom_range(1));
`endif
    beats.delete();
    mon_en = 1'b1;
    rampv  = $urandom;
    repeat ($urandom_range(1, 3)) drive(1'b1, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, $urandom, 1'b1, 1'b0, 1'b1, 1'b0);
    s  = cyc + 1;
    td = $urandom_range(0, 5);
    tw = $urandom_range(1, 3);
    for (int i = 0; i < 300; i++) begin
      v = rnd_vld ? ($urandom_range(3) != 0) : 1'b1;
      d = ramp ? rampv + 32'(i) : $urandom;
      r = (rdy_mode == 2) ? ($urandom_range(9) < 6) : (rdy_mode == 1);
      t = (i >= td) && (i < td + tw);
      drive(v, d, r, t, 1'b0, 1'b0);
    end
    h_vld = m_axis_tvalid; h_dat = m_axis_tdata; h_last = m_axis_tlast;
    repeat (12) drive(1'b1, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
    lim = cyc;
    mon_en = 1'b0;

    k = 0;
    for (int n = s + 1; n <= lim; n++)
      if (lg_vld[n]) begin
        if (((k + 1) % (D + 1)) == 0) acc.push_back(n);
        k++;
      end
    e = -1;
    for (int n = s + 1; n <= lim; n++)
      if (lg_trg[n] && !lg_trg[n-1]) begin e = n; break; end
    foreach (acc[j]) if (acc[j] > e && cap.size() < T) cap.push_back(acc[j]);
    pend = -1;
    ovf  = 1'b0;
    foreach (cap[j]) begin
      if (pend < 0 || drain_at(pend, lim) <= cap[j]) begin
        pend   = cap[j];
        b.dat  = lg_dat[cap[j]];
        b.last = (j == T - 1);
        b.cyc  = drain_at(cap[j], lim);
        ex.push_back(b);
      end else begin
        ovf = 1'b1;
      end
    end

    chk("beat_count", 64'(beats.size()), 64'(ex.size()));
    for (int j = 0; j < ex.size() && j < beats.size(); j++) begin
      chk("beat_dat", beats[j].dat, ex[j].dat);
      chk("beat_last", beats[j].last, ex[j].last);
      chk("beat_cycle", 64'(beats[j].cyc), 64'(ex[j].cyc));
    end
    chk("end_count", sts_count, 64'(T));
    chk("end_overflow", sts_overflow, ovf);
    chk("end_state_done", sts_state, 2'd3);
    chk("end_busy", busy, 1'b0);
    chk("end_tvalid", m_axis_tvalid, 1'b0);
    if (rdy_mode == 0 && ex.size() > 0) begin
      chk("held_vld", h_vld, 1'b1);
      chk("held_dat", h_dat, ex[0].dat);
      chk("held_last", h_last, ex[0].last);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, sts_state, 2'd0);
    chk({tag, "_tvalid"}, m_axis_tvalid, 1'b0);
    chk({tag, "_tlast"}, m_axis_tlast, 1'b0);
    chk({tag, "_tdata"}, m_axis_tdata, 32'd0);
    chk({tag, "_ovf"}, sts_overflow, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_count"}, sts_count, 16'd0);
  endtask

  initial begin
    aresetn = 1'b0;
    cfg_total = '0; cfg_dec = '0; cfg_level = '0; cfg_chan = 1'b0;
    start = 1'b0; abort = 1'b0; trg_ext = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk_reset_vals("rst");
    aresetn = 1'b1;
    drive(1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_reset_vals("post_rst");

    run_burst(4, 0, 1, 1'b0, 1'b1);
    run_burst(3, 2, 1, 1'b0, 1'b1);
    run_burst(5, 0, 0, 1'b0, 1'b1);
    for (int it = 0; it < 8; it++)
      run_burst($urandom_range(1, 8), $urandom_range(0, 3), 2, 1'b1, 1'b0);

`ifdef ADC_ACQ_LEVEL_TRIG_EN
    cfg_level = 16'd100; cfg_chan = 1'b1; cfg_total = 16'd2; cfg_dec = 16'd0;
    beats.delete();
    mon_en = 1'b1;
    drive(1'b1, {16'd110, 16'h0000}, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, {16'd110, 16'h0011}, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, {16'd90,  16'h0022}, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, {16'd90,  16'h0033}, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, {16'd110, 16'h00AA}, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, {16'd120, 16'h00BB}, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) drive(1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b0;
    chk("lvl_count", 64'(beats.size()), 64'd2);
    if (beats.size() == 2) begin
      chk("lvl_beat0", beats[0].dat, {16'd110, 16'h00AA});
      chk("lvl_beat1", beats[1].dat, {16'd120, 16'h00BB});
      chk("lvl_last1", beats[1].last, 1'b1);
    end
    chk("lvl_state", sts_state, 2'd3);
`endif

    cfg_total = 16'd8; cfg_dec = 16'd0;
    drive(1'b1, $urandom, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, $urandom, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_pre_state", sts_state, 2'd2);
    chk("abort_pre_vld", m_axis_tvalid, 1'b1);
    chk("abort_pre_ovf", sts_overflow, 1'b1);
    drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_vld", m_axis_tvalid, 1'b0);
    chk("abort_state", sts_state, 2'd0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ovf_kept", sts_overflow, 1'b1);
    drive(1'b1, $urandom, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("start_abort_state", sts_state, 2'd0);
    cfg_total = 16'd0;
    drive(1'b1, $urandom, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("zero_total_state", sts_state, 2'd0);

    cfg_total = 16'd8;
    drive(1'b1, $urandom, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, $urandom, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_pre_state", sts_state, 2'd2);
    aresetn = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    repeat (2) drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    aresetn = 1'b1;
    repeat (2) drive(1'b1, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_rel_state", sts_state, 2'd0);
    chk("rst_rel_vld", m_axis_tvalid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
